// File: rtl/guardian_monitor_mc_if.sv
// Telemetry-in / alert-out bundle for one guardian_monitor_mc instance.
// slave is the monitor's view; master is the driving/consuming side.
interface guardian_monitor_mc_if #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 12,
  parameter int SCORE_W = 16
);
  logic                      enable;
  logic                      sample_valid;
  logic [NUM_CH*DATA_W-1:0]  sample_data;
  logic [15:0]               timing_margin;
  logic [SCORE_W-1:0]        cfg_thresh_hi;
  logic [SCORE_W-1:0]        cfg_thresh_lo;
  logic [SCORE_W-1:0]        anomaly_score;
  logic                      alert_valid;
  logic                      alert_ready;
  logic [15:0]               alert_block_id;
  logic [NUM_CH-1:0]         alert_ch_mask;
  logic [SCORE_W-1:0]        alert_score;
  logic [2:0]                state;

  modport slave (
    input  enable, sample_valid, sample_data, timing_margin,
    input  cfg_thresh_hi, cfg_thresh_lo, alert_ready,
    output anomaly_score, alert_valid, alert_block_id, alert_ch_mask,
    output alert_score, state
  );

  modport master (
    output enable, sample_valid, sample_data, timing_margin,
    output cfg_thresh_hi, cfg_thresh_lo, alert_ready,
    input  anomaly_score, alert_valid, alert_block_id, alert_ch_mask,
    input  alert_score, state
  );
endinterface

// File: rtl/guardian_monitor_mc.sv
// Multi-channel guardian: delta-based saturating anomaly score, persistence /
// hysteresis filter, and a latched valid/ready alert toward recovery control.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | monitoring disabled; re-primes the delta history on exit
//   MONITOR  | nominal; waiting for a score above cfg_thresh_hi
//   SUSPECT  | counting consecutive high scores; band between lo/hi holds
//   ALERT    | alert_valid asserted with captured score/mask until accepted
//   COOLDOWN | fixed hold-off after acceptance; score events ignored
module guardian_monitor_mc #(
  parameter int BLOCK_ID  = 0,
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 12,
  parameter int SCORE_W   = 16,
  parameter int CH_THRESH = 20,
  parameter int PERSIST   = 3,
  parameter int COOLDOWN  = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  guardian_monitor_mc_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MONITOR  = 3'd1,
    SUSPECT  = 3'd2,
    ALERT    = 3'd3,
    COOLDOWN_S = 3'd4
  } state_t;

  localparam int CNT_MAX = (PERSIST > COOLDOWN) ? PERSIST : COOLDOWN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // Wide enough for NUM_CH<=8 deltas plus the margin byte, and one bit past SCORE_W.
  localparam int SUM_A   = (DATA_W + 5 > SCORE_W + 1) ? DATA_W + 5 : SCORE_W + 1;
  localparam int SUM_W   = (SUM_A > 10) ? SUM_A : 10;
  localparam logic [SUM_W-1:0]  SAT_MAX = (SUM_W'(1) << SCORE_W) - SUM_W'(1);
  localparam logic [DATA_W:0]   THR     = (DATA_W+1)'(CH_THRESH);
  localparam logic [CNT_W-1:0]  PERSIST_C  = CNT_W'(PERSIST);
  localparam logic [CNT_W-1:0]  COOLDOWN_C = CNT_W'(COOLDOWN);

  state_t                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      alert_valid_q;
  logic [SCORE_W-1:0]        alert_score_q;
  logic [NUM_CH-1:0]         alert_mask_q;

  logic [NUM_CH*DATA_W-1:0]  prev_q;
  logic                      primed_q;
  logic [SCORE_W-1:0]        anomaly_score_q;
  logic [NUM_CH-1:0]         flags_q;
  logic                      event_q;

  logic [SUM_W-1:0]          sum_d;
  logic [SCORE_W-1:0]        score_d;
  logic [NUM_CH-1:0]         flags_d;
  logic [DATA_W:0]           ch_v, pv_v, dlt_v;
  logic                      accept;
  logic                      over_hi, under_lo;

  assign accept   = bus.enable && bus.sample_valid && (state_q != IDLE);
  assign over_hi  = anomaly_score_q >  bus.cfg_thresh_hi;
  assign under_lo = anomaly_score_q <= bus.cfg_thresh_lo;

  always_comb begin
    sum_d   = SUM_W'(bus.timing_margin[15:8]);
    flags_d = '0;
    ch_v    = '0;
    pv_v    = '0;
    dlt_v   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_v  = {1'b0, bus.sample_data[i*DATA_W +: DATA_W]};
      pv_v  = {1'b0, prev_q[i*DATA_W +: DATA_W]};
      dlt_v = (ch_v >= pv_v) ? (ch_v - pv_v) : (pv_v - ch_v);
      if (!primed_q) dlt_v = '0;
      flags_d[i] = (dlt_v >= THR);
      sum_d      = sum_d + SUM_W'(dlt_v);
    end
    score_d = (sum_d > SAT_MAX) ? {SCORE_W{1'b1}} : sum_d[SCORE_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q          <= '0;
      primed_q        <= 1'b0;
      anomaly_score_q <= '0;
      flags_q         <= '0;
      event_q         <= 1'b0;
    end else begin
      event_q <= accept;
      if (state_q == IDLE && bus.enable) primed_q <= 1'b0;
      if (accept) begin
        prev_q          <= bus.sample_data;
        primed_q        <= 1'b1;
        anomaly_score_q <= score_d;
        flags_q         <= flags_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      alert_valid_q <= 1'b0;
      alert_score_q <= '0;
      alert_mask_q  <= '0;
    end else if (!bus.enable) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      alert_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= MONITOR;
          cnt_q   <= '0;
        end
        MONITOR: begin
          if (event_q && over_hi) begin
            if (PERSIST == 1) begin
              state_q       <= ALERT;
              cnt_q         <= '0;
              alert_valid_q <= 1'b1;
              alert_score_q <= anomaly_score_q;
              alert_mask_q  <= flags_q;
            end else begin
              state_q <= SUSPECT;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        SUSPECT: begin
          if (event_q) begin
            if (over_hi) begin
              if (cnt_q + CNT_W'(1) == PERSIST_C) begin
                state_q       <= ALERT;
                cnt_q         <= '0;
                alert_valid_q <= 1'b1;
                alert_score_q <= anomaly_score_q;
                alert_mask_q  <= flags_q;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end else if (under_lo) begin
              state_q <= MONITOR;
              cnt_q   <= '0;
            end
          end
        end
        ALERT: begin
          if (alert_valid_q && bus.alert_ready) begin
            alert_valid_q <= 1'b0;
            state_q       <= COOLDOWN_S;
            cnt_q         <= COOLDOWN_C;
          end
        end
        COOLDOWN_S: begin
          // Terminal count at 1 so the FSM sits in COOLDOWN for exactly COOLDOWN cycles.
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= MONITOR;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.anomaly_score  = anomaly_score_q;
  assign bus.alert_valid    = alert_valid_q;
  assign bus.alert_block_id = 16'(BLOCK_ID);
  assign bus.alert_ch_mask  = alert_mask_q;
  assign bus.alert_score    = alert_score_q;
  assign bus.state          = state_q;

endmodule

// File: doc/guardian_monitor_mc.md
Name: guardian_monitor_mc

Overview:
Multi-channel successor to the single-block guardian. It takes NUM_CH telemetry channels plus a timing margin and computes a saturating delta-based anomaly score on every valid sample. A persistence/hysteresis state machine filters that score, and the block raises a latched, handshaked alert to the recovery controller. Each instance sits beside one protected compute element, and the block is parametrised in channel count, width, persistence and cooldown.

Parameters:
BLOCK_ID, 0, identifier reported with every alert
NUM_CH, 4, number of telemetry channels (1..8)
DATA_W, 12, width of each channel sample
SCORE_W, 16, score width; all sums saturate at 2^SCORE_W-1
CH_THRESH, 20, per-channel |delta| at or above which the channel is flagged in the mask
PERSIST, 3, consecutive over-threshold samples needed to alert (>=1)
COOLDOWN, 16, cycles spent in COOLDOWN after an alert is accepted (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  monitoring enable
sample_valid  in  1  sample_data/timing_margin valid this cycle
sample_data  in  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
timing_margin  in  16  slack code; bits [15:8] are added to the score
cfg_thresh_hi  in  SCORE_W  alert-arming threshold (strict >)
cfg_thresh_lo  in  SCORE_W  clear threshold (<=); cfg_thresh_lo <= cfg_thresh_hi is required
anomaly_score  out  SCORE_W  last computed score
alert_valid  out  1  alert pending
alert_ready  in  1  consumer accepts alert
alert_block_id  out  16  BLOCK_ID, zero-extended
alert_ch_mask  out  NUM_CH  channels flagged in the triggering sample
alert_score  out  SCORE_W  score that triggered the alert
state  out  3  IDLE=0, MONITOR=1, SUSPECT=2, ALERT=3, COOLDOWN=4

Behaviour:
- Reset values (async assert, sync release):
  - All outputs 0, except alert_block_id=BLOCK_ID and state=IDLE.
  - Previous-sample registers 0; primed=0; persistence counter 0; cooldown counter 0.
- Score computation, on sample_valid while enable=1 and state is not IDLE:
  - d_i = |ch_i - prev_i|, computed in DATA_W+1 bits.
  - score = sat(sum d_i + timing_margin[15:8]).
  - If primed=0, every d_i is forced to 0, so the score equals timing_margin[15:8].
  - prev_i <= ch_i; primed <= 1.
  - anomaly_score and the per-channel flags (d_i >= CH_THRESH) are registered one cycle after sample_valid. The FSM evaluates that registered score in the following cycle ("score event").
- FSM:
  - IDLE: enable=1 -> MONITOR; primed is cleared on entry.
  - MONITOR: score event with score > hi -> counter=1; if PERSIST=1 go to ALERT, else go to SUSPECT.
  - SUSPECT:
    - score > hi -> counter++; at counter==PERSIST go to ALERT.
    - score <= lo -> counter=0, go to MONITOR.
    - lo < score <= hi -> stay; counter is held (hysteresis band).
  - ALERT:
    - On entry, alert_valid=1, and alert_score/alert_ch_mask are captured from the triggering event.
    - The captured values are held stable until alert_valid & alert_ready. Later samples do not modify them.
    - On the handshake, alert_valid drops the next cycle and the FSM goes to COOLDOWN with counter=COOLDOWN.
  - COOLDOWN: decrements every cycle and ignores score events; at 0 -> MONITOR with counter=0.
- enable=0 in any state:
  - Next state is IDLE and alert_valid is cleared, so a pending alert is dropped.
  - Counters are cleared; captured alert fields keep their values.
- Samples arriving while the FSM is in ALERT or COOLDOWN still update prev_i and anomaly_score.
- If alert_ready is already high on the cycle alert_valid rises, the handshake completes in that first cycle.
- Reset mid-alert: all outputs return to reset values immediately.

Test Plan:
1. Reset, enable, NUM_CH=4, 4 samples of ch=100, margin=0: anomaly_score=0 for every sample, state stays MONITOR, alert_valid=0.
2. hi=80, lo=40, PERSIST=3. Samples alternate ch0 between 100 and 200 (score 100): state goes MONITOR -> SUSPECT -> SUSPECT -> ALERT on the 3rd over-threshold event, alert_score=100, alert_ch_mask=4'b0001.
3. Persistence with hysteresis: scores 100, 60, 100, 100 -> alert after the 4th event (the 60 holds the counter). Scores 100, 30, 100 -> returns to MONITOR, no alert.
4. Alert pending, alert_ready low for 10 cycles with new samples arriving: alert_score/mask unchanged. Raise ready -> alert_valid drops next cycle, state=COOLDOWN for exactly 16 cycles, then MONITOR.
5. Saturation: NUM_CH=8, SCORE_W=8, all channels jump 0 -> 4095 with margin=16'hFF00: anomaly_score=255.
6. Drop enable while in ALERT -> alert_valid=0 next cycle, state=IDLE. Re-enable: the first sample scores margin[15:8] only. Assert rst_n low mid-COOLDOWN -> all outputs reset asynchronously.
